// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants, FSM encoding and helpers for the calculator sequencer
// Contents: op_code values, operand/result widths, EXEC step count, state enum,
//           priority picker for simultaneous key events, zero-extension helper.
package calc_pkg;

    localparam int OPERAND_W  = 4;
    localparam int RESULT_W   = 8;
    localparam int EXEC_STEPS = 4;
    localparam int STEP_W     = $clog2(EXEC_STEPS);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_SHOW = 2'd2
    } state_e;

    // Lowest key index wins when several press events land in the same cycle.
    function automatic logic [1:0] pick_op(input logic [3:0] ev);
        if (ev[0])      return OP_ADD;
        else if (ev[1]) return OP_SUB;
        else if (ev[2]) return OP_MUL;
        else            return OP_DIV;
    endfunction

    function automatic logic [RESULT_W-1:0] zext(input logic [OPERAND_W-1:0] v);
        return {{(RESULT_W-OPERAND_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-FF synchronizer, debounce counter and press pulse for one key
// Ports: clk, rst (sync, active-high), key_n (raw active-low button),
//        press (one-cycle pulse on a debounced press).
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q != level_q) begin
                // The DEBOUNCE_CYCLES-th consecutive differing sample commits the new level.
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_q <= sync2_q;
                    press_q <= ~sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - key-driven sequencer and multi-cycle datapath for the 4-bit calculator
// Ports: clk, rst (sync, active-high); sw_a/sw_b raw operand switches; key_n raw
//        active-low op buttons [0]=add [1]=sub [2]=mul [3]=div; op_a/op_b/op_code
//        latched request; result/error held for display; busy during EXEC; done pulse.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPERAND_W-1:0] sw_a,
    input  logic [OPERAND_W-1:0] sw_b,
    input  logic [3:0]           key_n,
    output logic [OPERAND_W-1:0] op_a,
    output logic [OPERAND_W-1:0] op_b,
    output logic [1:0]           op_code,
    output logic [RESULT_W-1:0]  result,
    output logic                 error,
    output logic                 busy,
    output logic                 done
);

    logic [3:0] press;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk   (clk),
            .rst   (rst),
            .key_n (key_n[i]),
            .press (press[i])
        );
    end

    state_e                  state_q;
    logic [OPERAND_W-1:0]    op_a_q;
    logic [OPERAND_W-1:0]    op_b_q;
    logic [1:0]              op_code_q;
    logic [RESULT_W-1:0]     result_q;
    logic                    error_q;
    logic                    busy_q;
    logic                    done_q;
    logic [STEP_W-1:0]       step_q;
    logic [RESULT_W-1:0]     acc_q;
    logic [OPERAND_W-1:0]    rem_q;
    logic [EXEC_STEPS-2:0]   quot_q;

    logic                    last_step;
    logic [RESULT_W-1:0]     mul_d;
    logic [OPERAND_W:0]      div_shift;
    logic                    div_qbit;
    logic [OPERAND_W-1:0]    div_diff;
    logic [OPERAND_W-1:0]    rem_d;
    logic                    fin;
    logic [RESULT_W-1:0]     fin_result;
    logic                    fin_error;

    always_comb begin
        last_step  = (step_q == STEP_W'(EXEC_STEPS - 1));

        // Shift-and-add: bit step_q of B adds A<<step_q.
        mul_d      = acc_q + (op_b_q[step_q] ? (zext(op_a_q) << step_q) : '0);

        // Restoring division, dividend bits taken MSB first. When the subtract
        // succeeds the true difference is below B, so 4 bits hold it exactly.
        div_shift  = {rem_q, op_a_q[STEP_W'(OPERAND_W - 1) - step_q]};
        div_qbit   = (div_shift >= {1'b0, op_b_q});
        div_diff   = div_shift[OPERAND_W-1:0] - op_b_q;
        rem_d      = div_qbit ? div_diff : div_shift[OPERAND_W-1:0];

        fin        = 1'b0;
        fin_result = '0;
        fin_error  = 1'b0;
        case (op_code_q)
            OP_ADD: begin
                fin        = 1'b1;
                fin_result = zext(op_a_q) + zext(op_b_q);
            end
            OP_SUB: begin
                fin = 1'b1;
                if (op_a_q >= op_b_q) fin_result = zext(op_a_q - op_b_q);
                else                  fin_error  = 1'b1;
            end
            OP_MUL: begin
                fin        = last_step;
                fin_result = mul_d;
            end
            default: begin
                // Divide by zero is caught on the first EXEC cycle.
                if (op_b_q == '0) begin
                    fin       = 1'b1;
                    fin_error = 1'b1;
                end else begin
                    fin        = last_step;
                    fin_result = zext({quot_q, div_qbit});
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_code_q <= OP_ADD;
            result_q  <= '0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            step_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_SHOW: begin
                    if (|press) begin
                        op_a_q    <= sw_a;
                        op_b_q    <= sw_b;
                        op_code_q <= pick_op(press);
                        step_q    <= '0;
                        acc_q     <= '0;
                        rem_q     <= '0;
                        quot_q    <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Press events arriving here are dropped, not queued.
                    if (fin) begin
                        result_q <= fin_result;
                        error_q  <= fin_error;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_SHOW;
                    end else begin
                        step_q <= step_q + 1'b1;
                        acc_q  <= mul_d;
                        rem_q  <= rem_d;
                        quot_q <= {quot_q[EXEC_STEPS-3:0], div_qbit};
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign op_a    = op_a_q;
    assign op_b    = op_b_q;
    assign op_code = op_code_q;
    assign result  = result_q;
    assign error   = error_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb/tb_calc_seq_ctrl.sv - directed scoreboard bench for calc_seq_ctrl
module tb_calc_seq_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_a, sw_b, key_n;
    logic [3:0] op_a, op_b;
    logic [1:0] op_code;
    logic [7:0] result;
    logic       error, busy, done;

    typedef struct packed {
        logic [7:0] res;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    calc_seq_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .sw_a(sw_a), .sw_b(sw_b), .key_n(key_n),
        .op_a(op_a), .op_b(op_b), .op_code(op_code), .result(result),
        .error(error), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        e.err = 1'b0;
        e.res = 8'd0;
        case (op)
            2'd0: e.res = 8'(a) + 8'(b);
            2'd1: if (a >= b) e.res = 8'(a) - 8'(b); else e.err = 1'b1;
            2'd2: e.res = 8'(a) * 8'(b);
            default: if (b == 4'd0) e.err = 1'b1; else e.res = 8'(a / b);
        endcase
        return e;
    endfunction

    // Press keys in 'mask', expect operation 'op'; optionally press key0 during EXEC.
    task automatic do_op(input string tag, input logic [3:0] mask, input logic [1:0] op,
                         input logic [3:0] a, input logic [3:0] b, input bit intr);
        int   n;
        int   bc;
        int   extra;
        exp_t e;
        int   exp_bc;
        exp_bc = (op == 2'd2 || (op == 2'd3 && b != 4'd0)) ? 4 : 1;
        @(negedge clk);
        sw_a  = a;
        sw_b  = b;
        key_n = ~mask;
        sb.push_back(model(op, a, b));
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (intr && n == 3) key_n[0] = 1'b0;
            if (busy) break;
        end
        chk({tag, "_latency"}, 32'(n), 32'(D + 3));
        sw_a = ~a;
        sw_b = ~b;
        bc = 1;
        while (bc < 30) begin
            @(negedge clk);
            if (!busy) break;
            bc++;
        end
        chk({tag, "_busy_cycles"}, 32'(bc), 32'(exp_bc));
        chk({tag, "_done"}, 32'(done), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_result"}, 32'(result), 32'(e.res));
            chk({tag, "_error"},  32'(error),  32'(e.err));
        end
        chk({tag, "_op_a"},    32'(op_a),    32'(a));
        chk({tag, "_op_b"},    32'(op_b),    32'(b));
        chk({tag, "_op_code"}, 32'(op_code), 32'(op));
        key_n = 4'hF;
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        extra = 0;
        repeat (14) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        chk({tag, "_no_extra"}, 32'(extra), 32'd0);
    endtask

    initial begin
        int act;
        rst   = 1'b1;
        key_n = 4'hF;
        sw_a  = 4'd0;
        sw_b  = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_error",  32'(error),  32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_opcode", 32'(op_code), 32'd0);
        chk("rst_ops",    32'({op_a, op_b}), 32'd0);

        do_op("add_9_7",   4'b0001, 2'd0, 4'd9,  4'd7,  1'b0);
        do_op("sub_3_5",   4'b0010, 2'd1, 4'd3,  4'd5,  1'b0);
        do_op("sub_5_3",   4'b0010, 2'd1, 4'd5,  4'd3,  1'b0);
        do_op("mul_15_15", 4'b0100, 2'd2, 4'd15, 4'd15, 1'b1);
        do_op("mul_11_6",  4'b0100, 2'd2, 4'd11, 4'd6,  1'b0);
        do_op("div_13_4",  4'b1000, 2'd3, 4'd13, 4'd4,  1'b0);
        do_op("div_15_1",  4'b1000, 2'd3, 4'd15, 4'd1,  1'b0);
        do_op("div_7_0",   4'b1000, 2'd3, 4'd7,  4'd0,  1'b0);

        // Three-cycle glitch on key0 must not produce an event.
        @(negedge clk);
        key_n = 4'b1110;
        repeat (3) @(negedge clk);
        key_n = 4'hF;
        act = 0;
        repeat (16) begin
            @(negedge clk);
            if (busy || done) act++;
        end
        chk("glitch_no_event", 32'(act), 32'd0);
        chk("glitch_hold_err", 32'(error), 32'd1);

        do_op("same_cycle_add", 4'b1001, 2'd0, 4'd6, 4'd9, 1'b0);

        // Reset during the second DIV EXEC cycle.
        @(negedge clk);
        sw_a  = 4'd13;
        sw_b  = 4'd4;
        key_n = 4'b0111;
        act = 0;
        while (act < 30) begin
            @(negedge clk);
            act++;
            if (busy) break;
        end
        chk("rst_div_started", 32'(busy), 32'd1);
        chk("rst_div_opcode",  32'(op_code), 32'd3);
        @(negedge clk);
        rst   = 1'b1;
        key_n = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_error",  32'(error),  32'd0);
        chk("midrst_busy",   32'(busy),   32'd0);
        chk("midrst_done",   32'(done),   32'd0);
        chk("midrst_ops",    32'({op_a, op_b, op_code}), 32'd0);
        act = 0;
        repeat (16) begin
            @(negedge clk);
            if (busy || done) act++;
        end
        chk("midrst_no_done", 32'(act), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
